// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch program-counter sequencer with redirect, halt and fault handling
module pc_sequencer #(
  parameter int               XLEN         = 64,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               INSTR_BYTES  = 4,
  parameter int               CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              trap,
  input  logic [XLEN-1:0]   trap_vector,
  input  logic              halt,
  input  logic              resume,
  output logic [XLEN-1:0]   PC_Out,
  output logic              fetch_valid,
  output logic              misaligned,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  redirect_count
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

  state_t             r_state;
  logic [XLEN-1:0]    r_pc;
  logic               r_fetch_valid;
  logic               r_misaligned;
  logic [CNT_W-1:0]   r_count;

  logic               w_trap_ok;
  logic               w_branch_ok;
  logic [CNT_W-1:0]   w_count_next;

  assign w_trap_ok    = (trap_vector & ALIGN_MASK) == '0;
  assign w_branch_ok  = (branch_target & ALIGN_MASK) == '0;
  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign w_count_next = (&r_count) ? r_count : r_count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_VECTOR;
      r_fetch_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_count       <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state       <= S_RUN;
          r_fetch_valid <= 1'b1;
        end
        S_RUN: begin
          if (trap) begin
            if (w_trap_ok) begin
              r_pc    <= trap_vector;
              r_count <= w_count_next;
            end else begin
              r_misaligned  <= 1'b1;
              r_state       <= S_FAULT;
              r_fetch_valid <= 1'b0;
            end
          end else if (halt) begin
            r_state       <= S_HALT;
            r_fetch_valid <= 1'b0;
          end else if (branch_taken) begin
            if (w_branch_ok) begin
              r_pc    <= branch_target;
              r_count <= w_count_next;
            end else begin
              r_misaligned  <= 1'b1;
              r_state       <= S_FAULT;
              r_fetch_valid <= 1'b0;
            end
          end else if (!stall) begin
            r_pc <= r_pc + PC_STEP;
          end
        end
        S_HALT: begin
          if (trap && w_trap_ok) begin
            r_pc          <= trap_vector;
            r_count       <= w_count_next;
            r_state       <= S_RUN;
            r_fetch_valid <= 1'b1;
          end else if (resume) begin
            r_state       <= S_RUN;
            r_fetch_valid <= 1'b1;
          end
        end
        S_FAULT: begin
          // Only an aligned trap clears the fault; everything else is ignored.
          if (trap && w_trap_ok) begin
            r_pc          <= trap_vector;
            r_misaligned  <= 1'b0;
            r_count       <= w_count_next;
            r_state       <= S_RUN;
            r_fetch_valid <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_BOOT;
          r_fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  assign PC_Out         = r_pc;
  assign fetch_valid    = r_fetch_valid;
  assign misaligned     = r_misaligned;
  assign state          = r_state;
  assign redirect_count = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        trap;
  logic [63:0] trap_vector;
  logic        halt;
  logic        resume;
  logic [63:0] PC_Out;
  logic        fetch_valid;
  logic        misaligned;
  logic [1:0]  state;
  logic [15:0] redirect_count;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(
    .XLEN(64), .RESET_VECTOR(64'h1000), .INSTR_BYTES(4), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .trap(trap), .trap_vector(trap_vector),
    .halt(halt), .resume(resume), .PC_Out(PC_Out), .fetch_valid(fetch_valid),
    .misaligned(misaligned), .state(state), .redirect_count(redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl bits: [4] stall, [3] branch_taken, [2] trap, [1] halt, [0] resume
  typedef struct {
    logic [4:0]  ctrl;
    logic [63:0] bt;
    logic [63:0] tv;
    logic [63:0] pc;
    logic        fv;
    logic        mis;
    logic [1:0]  st;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [4:0] ctrl, logic [63:0] bt, logic [63:0] tv,
                              logic [63:0] pc, logic fv, logic mis, logic [1:0] st,
                              logic [15:0] cnt);
    vec_t v;
    v.ctrl = ctrl; v.bt = bt; v.tv = tv; v.pc = pc;
    v.fv = fv; v.mis = mis; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [63:0] pc, logic fv, logic mis,
                           logic [1:0] st, logic [15:0] cnt);
    check({tag, ".pc"},    PC_Out, pc);
    check({tag, ".fv"},    {63'd0, fetch_valid}, {63'd0, fv});
    check({tag, ".mis"},   {63'd0, misaligned}, {63'd0, mis});
    check({tag, ".state"}, {62'd0, state}, {62'd0, st});
    check({tag, ".cnt"},   {48'd0, redirect_count}, {48'd0, cnt});
  endtask

  task automatic drive(logic [4:0] ctrl, logic [63:0] bt, logic [63:0] tv);
    stall         = ctrl[4];
    branch_taken  = ctrl[3];
    trap          = ctrl[2];
    halt          = ctrl[1];
    resume        = ctrl[0];
    branch_target = bt;
    trap_vector   = tv;
  endtask

  initial begin
    reset = 1'b1;
    drive(5'b00000, 64'h0, 64'h0);

    // RUN sequence, stall, branch/stall, misaligned fault and recovery
    vecs.push_back(mk(5'b00000, 64'h0,    64'h0,   64'h1000, 1'b1, 1'b0, 2'd1, 16'd0));
    vecs.push_back(mk(5'b00000, 64'h0,    64'h0,   64'h1004, 1'b1, 1'b0, 2'd1, 16'd0));
    vecs.push_back(mk(5'b00000, 64'h0,    64'h0,   64'h1008, 1'b1, 1'b0, 2'd1, 16'd0));
    vecs.push_back(mk(5'b10000, 64'h0,    64'h0,   64'h1008, 1'b1, 1'b0, 2'd1, 16'd0));
    vecs.push_back(mk(5'b10000, 64'h0,    64'h0,   64'h1008, 1'b1, 1'b0, 2'd1, 16'd0));
    vecs.push_back(mk(5'b11000, 64'h2000, 64'h0,   64'h2000, 1'b1, 1'b0, 2'd1, 16'd1));
    vecs.push_back(mk(5'b00000, 64'h0,    64'h0,   64'h2004, 1'b1, 1'b0, 2'd1, 16'd1));
    vecs.push_back(mk(5'b01000, 64'h2002, 64'h0,   64'h2004, 1'b0, 1'b1, 2'd3, 16'd1));
    vecs.push_back(mk(5'b00000, 64'h0,    64'h0,   64'h2004, 1'b0, 1'b1, 2'd3, 16'd1));
    vecs.push_back(mk(5'b00100, 64'h0,    64'h102, 64'h2004, 1'b0, 1'b1, 2'd3, 16'd1));
    vecs.push_back(mk(5'b01001, 64'h3000, 64'h0,   64'h2004, 1'b0, 1'b1, 2'd3, 16'd1));
    vecs.push_back(mk(5'b00100, 64'h0,    64'h100, 64'h100,  1'b1, 1'b0, 2'd1, 16'd2));
    // halt with concurrent branch, resume
    vecs.push_back(mk(5'b01010, 64'h4000, 64'h0,   64'h100,  1'b0, 1'b0, 2'd2, 16'd2));
    vecs.push_back(mk(5'b00000, 64'h0,    64'h0,   64'h100,  1'b0, 1'b0, 2'd2, 16'd2));
    vecs.push_back(mk(5'b11000, 64'h5000, 64'h0,   64'h100,  1'b0, 1'b0, 2'd2, 16'd2));
    vecs.push_back(mk(5'b00001, 64'h0,    64'h0,   64'h100,  1'b1, 1'b0, 2'd1, 16'd2));
    vecs.push_back(mk(5'b00000, 64'h0,    64'h0,   64'h104,  1'b1, 1'b0, 2'd1, 16'd2));
    // trap beats halt and branch; trap out of HALT; misaligned trap in RUN
    vecs.push_back(mk(5'b01110, 64'h6000, 64'h200, 64'h200,  1'b1, 1'b0, 2'd1, 16'd3));
    vecs.push_back(mk(5'b00010, 64'h0,    64'h0,   64'h200,  1'b0, 1'b0, 2'd2, 16'd3));
    vecs.push_back(mk(5'b00100, 64'h0,    64'h300, 64'h300,  1'b1, 1'b0, 2'd1, 16'd4));
    vecs.push_back(mk(5'b00100, 64'h0,    64'h301, 64'h300,  1'b0, 1'b1, 2'd3, 16'd4));
    vecs.push_back(mk(5'b00100, 64'h0,    64'h400, 64'h400,  1'b1, 1'b0, 2'd1, 16'd5));
    // PC wrap at the top of the address space
    vecs.push_back(mk(5'b01000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,
                      64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 2'd1, 16'd6));
    vecs.push_back(mk(5'b00000, 64'h0,    64'h0,   64'h0,    1'b1, 1'b0, 2'd1, 16'd6));
    vecs.push_back(mk(5'b00000, 64'h0,    64'h0,   64'h4,    1'b1, 1'b0, 2'd1, 16'd6));

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 64'h1000, 1'b0, 1'b0, 2'd0, 16'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctrl, vecs[i].bt, vecs[i].tv);
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].fv, vecs[i].mis,
                vecs[i].st, vecs[i].cnt);
    end

    // Asynchronous reset mid-cycle, between clock edges
    drive(5'b00000, 64'h0, 64'h0);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 64'h1000, 1'b0, 1'b0, 2'd0, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("reboot", 64'h1000, 1'b1, 1'b0, 2'd1, 16'd0);

    // Redirect counter saturation
    drive(5'b01000, 64'h2000, 64'h0);
    repeat (65534) @(posedge clk);
    #1;
    check("sat.cnt_fffe", {48'd0, redirect_count}, 64'hFFFE);
    @(posedge clk);
    #1;
    check("sat.cnt_ffff", {48'd0, redirect_count}, 64'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sat.cnt_hold", {48'd0, redirect_count}, 64'hFFFF);
    check("sat.pc", PC_Out, 64'h2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
